ps2_key_decoder: RTL

- Sits between the ps2_keyboard receiver FIFO and consumers such as the VGA text path, seven-segment display and LEDs.
- Pops raw scan-code bytes from the receiver and decodes them into key events, handling the E0 (extended) and F0 (break) prefixes.
- Optionally filters typematic repeats of the held key.
- Counts key presses and tracks the currently held key.
- Buffers events in a small show-ahead FIFO with a valid/ready handshake.

---
 rtl/ps2_key_decoder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// Decodes PS/2 set-2 scan-code bytes (E0/F0 prefixes) into key events, tracks the held key,
// counts presses and queues events in a show-ahead FIFO with a valid/ready handshake.
module ps2_key_decoder #(
  parameter int CNT_W            = 8,
  parameter int EV_DEPTH         = 4,
  parameter int TYPEMATIC_FILTER = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kb_ready,
  input  logic [7:0]       kb_data,
  output logic             kb_nextdata_n,
  output logic             ev_valid,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  input  logic             ev_ready,
  output logic             held,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_cnt,
  input  logic             clr_cnt,
  output logic             ev_overflow
);

  localparam int AW = $clog2(EV_DEPTH);

  typedef enum logic {IDLE, DECODE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             ext_q, ext_d, brk_q, brk_d;
  logic             held_q, held_d;
  logic [7:0]       held_code_q, held_code_d;
  logic             held_ext_q, held_ext_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [9:0]       mem_q [EV_DEPTH];
  logic [9:0]       mem_d [EV_DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;

  logic       push, pop, full, empty, key_match;
  logic [9:0] ev_entry, head;

  // Decoder FSM, prefix flags, held-key tracking and press counter.
  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    ext_d         = ext_q;
    brk_d         = brk_q;
    held_d        = held_q;
    held_code_d   = held_code_q;
    held_ext_d    = held_ext_q;
    cnt_d         = cnt_q;
    kb_nextdata_n = 1'b1;
    push          = 1'b0;
    ev_entry      = {byte_q, ext_q, brk_q};
    key_match     = held_q && (held_code_q == byte_q) && (held_ext_q == ext_q);

    if (state_q == IDLE) begin
      if (kb_ready && !rst) begin
        byte_d        = kb_data;
        kb_nextdata_n = 1'b0;
        state_d       = DECODE;
      end
    end else begin
      state_d = IDLE;
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (byte_q inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!brk_q) begin
          held_d      = 1'b1;
          held_code_d = byte_q;
          held_ext_d  = ext_q;
          // A repeat of the already-held key is typematic, not a new press.
          if (!((TYPEMATIC_FILTER != 0) && key_match)) begin
            push  = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          push = 1'b1;
          if (key_match) held_d = 1'b0;
        end
      end
    end

    if (clr_cnt) cnt_d = '0;
  end

  // Event FIFO: pointers carry one extra wrap bit to tell full from empty.
  always_comb begin
    empty = (wr_q == rd_q);
    full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop   = !empty && ev_ready;
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (push) begin
      if (!full || pop) begin
        mem_d[wr_q[AW-1:0]] = ev_entry;
        wr_d = wr_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (pop) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_q      <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      held_q      <= 1'b0;
      held_code_q <= '0;
      held_ext_q  <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      for (int i = 0; i < EV_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      held_q      <= held_d;
      held_code_q <= held_code_d;
      held_ext_q  <= held_ext_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      for (int i = 0; i < EV_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign head        = mem_q[rd_q[AW-1:0]];
  assign ev_valid    = !empty;
  assign ev_code     = ev_valid ? head[9:2] : 8'h00;
  assign ev_ext      = ev_valid & head[1];
  assign ev_break    = ev_valid & head[0];
  assign held        = held_q;
  assign held_code   = held_code_q;
  assign held_ext    = held_ext_q;
  assign press_cnt   = cnt_q;
  assign ev_overflow = ovf_q;

endmodule
